// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: block geometry, address width and the
// next-level responder state encoding.
package cache_pkg;

    localparam int ADDR_W    = 32;
    localparam int BLOCKSIZE = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } l2_state_t;

    // Byte-offset bits within a block; also used by the cache tag/index split.
    function automatic int offset_bits(input int blocksize);
        return $clog2(blocksize);
    endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// Request/response handshake between the cache miss path and the L2 responder.
interface l2_mem_responder_if;
    import cache_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_write;
    logic [ADDR_W-1:0] resp_tag;

    modport master (
        output req_valid, req_write, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_tag
    );

    modport slave (
        input  req_valid, req_write, req_addr, resp_ready,
        output req_ready, resp_valid, resp_write, resp_tag
    );

endinterface

// File: rtl/l2_mem_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/l2_mem_responder.sv
// Next-level memory responder: one block request at a time, fixed read/write
// latency, saturating traffic statistics. Carries no data.
module l2_mem_responder
    import cache_pkg::*;
#(
    parameter int BLOCKSIZE     = cache_pkg::BLOCKSIZE,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int CNT_W         = 12
) (
    input  logic             clk,
    input  logic             reset,
    l2_mem_responder_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] num_reads,
    output logic [CNT_W-1:0] num_writes
);

    localparam int OFF_W   = offset_bits(BLOCKSIZE);
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);

    l2_state_t         state;
    logic [LAT_W-1:0]  cnt;
    logic              resp_valid_q;
    logic              resp_write_q;
    logic [ADDR_W-1:0] resp_tag_q;
    logic              accept;

    assign accept         = bus.req_valid && (state == ST_IDLE);
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_tag   = resp_tag_q;
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        resp_tag_q   <= bus.req_addr >> OFF_W;
                        resp_write_q <= bus.req_write;
                        cnt          <= bus.req_write ? LAT_W'(WRITE_LATENCY)
                                                      : LAT_W'(READ_LATENCY);
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Terminal count of 1 so a latency of L lands RESP exactly L edges after accept.
                    if (cnt == LAT_W'(1)) begin
                        cnt          <= '0;
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_reads (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && !bus.req_write),
        .clear (1'b0),
        .count (num_reads)
    );

    sat_counter #(.W(CNT_W)) u_writes (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && bus.req_write),
        .clear (1'b0),
        .count (num_writes)
    );

endmodule
